// File: rtl/cram_wr_sched.sv
// CRAM palette write-port scheduler: arbitrates buffered Z80 writes and DMA words
// with strict alternation, optionally restricted to the active blanking window.
module cram_wr_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blank_only,
  input  logic        blank,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [14:0] cpu_data,
  output logic        cpu_full,
  output logic        ovf,
  input  logic        ovf_clr,
  input  logic        dma_req,
  input  logic [7:0]  dma_addr,
  input  logic [14:0] dma_data,
  output logic        dma_ack,
  output logic        cram_we,
  output logic [7:0]  cram_addr,
  output logic [14:0] cram_data,
  output logic        busy
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [22:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          last_cpu_q, last_cpu_d;
  logic          we_q, we_d;
  logic          ack_q, ack_d;
  logic [7:0]    addr_q, addr_d;
  logic [14:0]   data_q, data_d;

  logic cpu_pend, dma_pend, win, push, grant_cpu, grant_dma;

  always_comb begin
    cpu_pend  = (count_q != '0);
    // The word just acked is still on dma_addr/dma_data this cycle; mask it.
    dma_pend  = dma_req & ~ack_q;
    win       = ~blank_only | blank;
    // Full is judged on the registered flag, so a same-cycle pop never frees a slot.
    push      = cpu_we & ~full_q;
    grant_cpu = win & cpu_pend & (~dma_pend | ~last_cpu_q);
    grant_dma = win & dma_pend & (~cpu_pend | last_cpu_q);

    wptr_d = push      ? wptr_q + 1'b1 : wptr_q;
    rptr_d = grant_cpu ? rptr_q + 1'b1 : rptr_q;
    case ({push, grant_cpu})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == FULL_CNT);

    ovf_d      = (cpu_we & full_q) | (ovf_q & ~ovf_clr);
    last_cpu_d = (grant_cpu | grant_dma) ? grant_cpu : last_cpu_q;
    we_d       = grant_cpu | grant_dma;
    ack_d      = grant_dma;
    addr_d     = addr_q;
    data_d     = data_q;
    if (grant_cpu) begin
      {addr_d, data_d} = mem_q[rptr_q];
    end else if (grant_dma) begin
      addr_d = dma_addr;
      data_d = dma_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {cpu_addr, cpu_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      last_cpu_q <= 1'b0;
      we_q       <= 1'b0;
      ack_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      last_cpu_q <= last_cpu_d;
      we_q       <= we_d;
      ack_q      <= ack_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign cpu_full  = full_q;
  assign ovf       = ovf_q;
  assign dma_ack   = ack_q;
  assign cram_we   = we_q;
  assign cram_addr = addr_q;
  assign cram_data = data_q;
  assign busy      = cpu_pend | dma_req;

endmodule
